// File: rtl/scan_chain_ctrl_if.sv
// rtl/scan_chain_ctrl_if.sv - host command/data and scan-chain signals of scan_chain_ctrl
interface scan_chain_ctrl_if #(
    parameter int SCAN_WIDTH = 1
);
    logic                  CMD_EN;
    logic [1:0]            CMD_OP;
    logic                  CMD_RDY;
    logic [SCAN_WIDTH-1:0] DIN_DATA;
    logic                  DIN_VALID;
    logic                  DIN_RDY;
    logic [SCAN_WIDTH-1:0] DOUT_DATA;
    logic                  DOUT_VALID;
    logic                  DOUT_RDY;
    logic                  DONE;
    logic                  ERR;
    logic                  BUSY;
    logic                  SCAN_ANY;
    logic                  SCAN_MODE;
    logic [SCAN_WIDTH-1:0] CHAIN_IN;
    logic [SCAN_WIDTH-1:0] CHAIN_OUT;

    modport master (
        output CMD_EN, CMD_OP, DIN_DATA, DIN_VALID, DOUT_RDY, CHAIN_OUT,
        input  CMD_RDY, DIN_RDY, DOUT_DATA, DOUT_VALID, DONE, ERR, BUSY,
               SCAN_ANY, SCAN_MODE, CHAIN_IN
    );

    modport slave (
        input  CMD_EN, CMD_OP, DIN_DATA, DIN_VALID, DOUT_RDY, CHAIN_OUT,
        output CMD_RDY, DIN_RDY, DOUT_DATA, DOUT_VALID, DONE, ERR, BUSY,
               SCAN_ANY, SCAN_MODE, CHAIN_IN
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - freezes a SampleReg chain and streams it out (read or exchange)
module scan_chain_ctrl #(
    parameter int SCAN_WIDTH = 1,
    parameter int DEPTH      = 8,
    parameter int CW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    scan_chain_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, HELD} state_t;

    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            cmd_rdy;
    logic            avail;
    logic            fire;
    logic [SCAN_WIDTH-1:0] chain_in;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        avail    = 1'b0;
        fire     = 1'b0;
        chain_in = bus.CHAIN_OUT;
        cmd_rdy  = (state_q == IDLE) || (state_q == HELD);

        if (cmd_rdy && bus.CMD_EN) begin
            case (bus.CMD_OP)
                2'b00, 2'b01: begin
                    op_d    = bus.CMD_OP[0];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
                2'b10:   state_d = IDLE;
                default: err_d   = 1'b1;
            endcase
        end

        // A stall leaves the chain untouched because SCAN_ANY stays high throughout SHIFT.
        if (state_q == SHIFT) begin
            avail    = op_q ? bus.DIN_VALID : 1'b1;
            fire     = avail && bus.DOUT_RDY;
            chain_in = op_q ? bus.DIN_DATA : bus.CHAIN_OUT;
            if (fire) begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = HELD;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    assign bus.CMD_RDY    = cmd_rdy;
    assign bus.BUSY       = (state_q == SHIFT);
    assign bus.SCAN_ANY   = (state_q != IDLE);
    assign bus.SCAN_MODE  = fire;
    assign bus.DOUT_VALID = avail;
    assign bus.DOUT_DATA  = bus.CHAIN_OUT;
    assign bus.DIN_RDY    = (state_q == SHIFT) && op_q && bus.DOUT_RDY;
    assign bus.CHAIN_IN   = chain_in;
    assign bus.DONE       = done_q;
    assign bus.ERR        = err_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - directed bench for scan_chain_ctrl with behavioural SampleReg chains
module tb_scan_chain_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    scan_chain_ctrl_if #(.SCAN_WIDTH(8)) if4 ();
    scan_chain_ctrl_if #(.SCAN_WIDTH(8)) if1 ();

    scan_chain_ctrl #(.SCAN_WIDTH(8), .DEPTH(4)) u4 (.CLK(clk), .RST_N(rst_n), .bus(if4));
    scan_chain_ctrl #(.SCAN_WIDTH(8), .DEPTH(1)) u1 (.CLK(clk), .RST_N(rst_n), .bus(if1));

    // Stage 0 is the tail; shifting moves every word one stage toward the tail.
    logic [7:0] ch4 [4];
    logic [7:0] d4  [4];
    logic [7:0] ch1;
    logic [7:0] d1;

    always @(posedge clk) begin
        if (!if4.SCAN_ANY) begin
            for (int i = 0; i < 4; i++) ch4[i] <= d4[i];
        end else if (if4.SCAN_MODE) begin
            for (int i = 0; i < 3; i++) ch4[i] <= ch4[i+1];
            ch4[3] <= if4.CHAIN_IN;
        end
        if (!if1.SCAN_ANY)     ch1 <= d1;
        else if (if1.SCAN_MODE) ch1 <= if1.CHAIN_IN;
    end

    assign if4.CHAIN_OUT = ch4[0];
    assign if1.CHAIN_OUT = ch1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read4_run(input logic [7:0] exp [4], input string tag);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk({tag, "_busy"}, if4.BUSY, 1);
            chk({tag, "_dvalid"}, if4.DOUT_VALID, 1);
            chk({tag, "_dout"}, if4.DOUT_DATA, exp[k]);
            chk({tag, "_smode"}, if4.SCAN_MODE, 1);
            chk({tag, "_dinrdy"}, if4.DIN_RDY, 0);
            chk({tag, "_done_early"}, if4.DONE, 0);
            step();
        end
        #1;
        chk({tag, "_done"}, if4.DONE, 1);
        chk({tag, "_busy_end"}, if4.BUSY, 0);
        chk({tag, "_held"}, if4.SCAN_ANY, 1);
        chk({tag, "_cmdrdy_held"}, if4.CMD_RDY, 1);
    endtask

    logic [7:0] orig [4];
    logic [7:0] xin  [4];
    logic       tv   [8];
    logic       tr   [8];

    initial begin
        int fires;
        n_checks = 0;
        n_errors = 0;
        orig = '{8'h11, 8'h22, 8'h33, 8'h44};
        xin  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        tv   = '{1, 1, 1, 0, 0, 0, 1, 1};
        tr   = '{1, 0, 1, 1, 1, 1, 1, 1};

        rst_n = 1'b0;
        d4 = orig;
        d1 = 8'h5A;
        if4.CMD_EN = 0; if4.CMD_OP = 0; if4.DIN_DATA = 0; if4.DIN_VALID = 0; if4.DOUT_RDY = 0;
        if1.CMD_EN = 0; if1.CMD_OP = 0; if1.DIN_DATA = 0; if1.DIN_VALID = 0; if1.DOUT_RDY = 0;
        step(); step(); step();
        chk("rst_scan_any", if4.SCAN_ANY, 0);
        chk("rst_scan_mode", if4.SCAN_MODE, 0);
        chk("rst_busy", if4.BUSY, 0);
        chk("rst_cmd_rdy", if4.CMD_RDY, 1);
        chk("rst_dout_valid", if4.DOUT_VALID, 0);
        chk("rst_din_rdy", if4.DIN_RDY, 0);
        chk("rst_done", if4.DONE, 0);
        chk("rst_err", if4.ERR, 0);
        rst_n = 1'b1;
        step();

        // READ with continuous DOUT_RDY; D_IN changes afterwards must not reach the frozen chain
        if4.CMD_EN = 1; if4.CMD_OP = 2'b00; if4.DOUT_RDY = 1;
        step();
        if4.CMD_EN = 0;
        d4 = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
        chk("read_scan_any_from_t", if4.SCAN_ANY, 1);
        read4_run(orig, "read1");
        for (int i = 0; i < 4; i++) chk("read1_chain_kept", ch4[i], orig[i]);
        step();
        chk("read1_done_pulse", if4.DONE, 0);
        chk("read1_still_held", if4.SCAN_ANY, 1);
        for (int i = 0; i < 4; i++) chk("read1_chain_frozen", ch4[i], orig[i]);

        // EXCHANGE from HELD with DOUT_RDY and DIN_VALID gaps
        if4.CMD_EN = 1; if4.CMD_OP = 2'b01;
        step();
        if4.CMD_EN = 0;
        fires = 0;
        for (int c = 0; c < 8; c++) begin
            if4.DIN_VALID = tv[c];
            if4.DOUT_RDY  = tr[c];
            if4.DIN_DATA  = (fires < 4) ? xin[fires] : 8'h00;
            #1;
            chk("xchg_busy", if4.BUSY, 1);
            chk("xchg_smode", if4.SCAN_MODE, tv[c] & tr[c]);
            chk("xchg_dvalid", if4.DOUT_VALID, tv[c]);
            chk("xchg_dinrdy", if4.DIN_RDY, tr[c]);
            chk("xchg_done_early", if4.DONE, 0);
            if (tv[c]) chk("xchg_dout", if4.DOUT_DATA, orig[fires]);
            if (tv[c] & tr[c]) fires++;
            step();
        end
        if4.DIN_VALID = 0;
        #1;
        chk("xchg_done", if4.DONE, 1);
        chk("xchg_busy_end", if4.BUSY, 0);
        for (int i = 0; i < 4; i++) chk("xchg_chain", ch4[i], xin[i]);

        // follow-up READ accepted in the DONE cycle
        if4.CMD_EN = 1; if4.CMD_OP = 2'b00; if4.DOUT_RDY = 1;
        chk("done_cycle_cmd_rdy", if4.CMD_RDY, 1);
        step();
        if4.CMD_EN = 0;
        read4_run(xin, "read2");
        step();

        // RELEASE from HELD
        if4.CMD_EN = 1; if4.CMD_OP = 2'b10;
        step();
        if4.CMD_EN = 0;
        chk("release_scan_any", if4.SCAN_ANY, 0);
        chk("release_cmd_rdy", if4.CMD_RDY, 1);

        // reserved opcode in IDLE, then RELEASE in IDLE
        if4.CMD_EN = 1; if4.CMD_OP = 2'b11;
        step();
        if4.CMD_EN = 0;
        chk("err_idle", if4.ERR, 1);
        chk("err_idle_scan_any", if4.SCAN_ANY, 0);
        chk("err_idle_busy", if4.BUSY, 0);
        step();
        chk("err_idle_pulse", if4.ERR, 0);
        if4.CMD_EN = 1; if4.CMD_OP = 2'b10;
        #1;
        chk("rel_idle_cmd_rdy", if4.CMD_RDY, 1);
        step();
        if4.CMD_EN = 0;
        chk("rel_idle_scan_any", if4.SCAN_ANY, 0);
        chk("rel_idle_err", if4.ERR, 0);
        chk("rel_idle_busy", if4.BUSY, 0);

        // reserved opcode in HELD
        d4 = orig;
        step();
        if4.CMD_EN = 1; if4.CMD_OP = 2'b00;
        step();
        if4.CMD_EN = 0;
        read4_run(orig, "read3");
        if4.CMD_EN = 1; if4.CMD_OP = 2'b11;
        step();
        if4.CMD_EN = 0;
        chk("err_held", if4.ERR, 1);
        chk("err_held_scan_any", if4.SCAN_ANY, 1);
        chk("err_held_busy", if4.BUSY, 0);
        step();
        chk("err_held_pulse", if4.ERR, 0);
        chk("err_held_stays", if4.SCAN_ANY, 1);
        if4.CMD_EN = 1; if4.CMD_OP = 2'b10;
        step();
        if4.CMD_EN = 0;
        chk("release2_scan_any", if4.SCAN_ANY, 0);

        // reset after 2 of 4 shifts
        if4.CMD_EN = 1; if4.CMD_OP = 2'b00;
        step();
        if4.CMD_EN = 0;
        step(); step();
        chk("pre_rst_busy", if4.BUSY, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_scan_any", if4.SCAN_ANY, 0);
        chk("mid_rst_busy", if4.BUSY, 0);
        chk("mid_rst_smode", if4.SCAN_MODE, 0);
        chk("mid_rst_dvalid", if4.DOUT_VALID, 0);
        step();
        chk("mid_rst_done", if4.DONE, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_cmd_rdy", if4.CMD_RDY, 1);
        chk("post_rst_done", if4.DONE, 0);
        chk("post_rst_scan_any", if4.SCAN_ANY, 0);
        if4.DOUT_RDY = 0;

        // DEPTH=1 READ
        if1.CMD_EN = 1; if1.CMD_OP = 2'b00; if1.DOUT_RDY = 1;
        step();
        if1.CMD_EN = 0;
        d1 = 8'h00;
        #1;
        chk("d1_busy", if1.BUSY, 1);
        chk("d1_dout", if1.DOUT_DATA, 8'h5A);
        chk("d1_smode", if1.SCAN_MODE, 1);
        chk("d1_done_early", if1.DONE, 0);
        step();
        chk("d1_done", if1.DONE, 1);
        chk("d1_busy_end", if1.BUSY, 0);
        chk("d1_held", if1.SCAN_ANY, 1);
        chk("d1_chain", ch1, 8'h5A);
        step();
        chk("d1_done_pulse", if1.DONE, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer for a chain of scan-capable sample registers, from the register's SCAN_ANY / SCAN_MODE / SCAN_IN / SCAN_OUT side. On host command it freezes the chain, then streams it out one stage per shift, either recirculating (non-destructive read) or exchanging host data in. It then holds the chain frozen until released. It sits between a debug/host port and the concatenated SampleReg chain, which it treats as DEPTH stages of SCAN_WIDTH bits.

## Interface
- SCAN_WIDTH, 1: bits per chain stage and per data word.
- DEPTH, 8: number of stages in the chain (>= 1); one full operation = DEPTH shifts.
- CW, $clog2(DEPTH) (min 1): shift counter width.

- CLK  in  1  sole clock; all state on posedge CLK.
- RST_N  in  1  asynchronous, active-low reset.
- CMD_EN  in  1  command valid.
- CMD_OP  in  2  00 READ, 01 EXCHANGE, 10 RELEASE, 11 reserved.
- CMD_RDY  out  1  command accepted when CMD_EN & CMD_RDY.
- DIN_DATA  in  SCAN_WIDTH  host word shifted into chain (EXCHANGE).
- DIN_VALID  in  1  DIN_DATA valid.
- DIN_RDY  out  1  DIN word consumed this cycle.
- DOUT_DATA  out  SCAN_WIDTH  current chain tail word.
- DOUT_VALID  out  1  DOUT_DATA offered.
- DOUT_RDY  in  1  host accepts DOUT word.
- DONE  out  1  one-cycle pulse after the last shift.
- ERR  out  1  one-cycle pulse on reserved opcode.
- BUSY  out  1  state == SHIFT.
- SCAN_ANY  out  1  chain frozen (to every SampleReg).
- SCAN_MODE  out  1  shift strobe (to every SampleReg).
- CHAIN_IN  out  SCAN_WIDTH  to head SCAN_IN.
- CHAIN_OUT  in  SCAN_WIDTH  from tail SCAN_OUT.

## Operation
- States: IDLE (chain samples D_IN), SHIFT, HELD (chain frozen, not shifting).
- Registers: state, op_r (1 bit: READ=0/EXCHANGE=1), cnt[CW-1:0], DONE, ERR.
- SCAN_ANY = (state != IDLE). CMD_RDY = (state == IDLE) | (state == HELD). BUSY = (state == SHIFT).
- Command in IDLE or HELD:
  - READ/EXCHANGE: op_r <= op; cnt <= 0; go to SHIFT.
  - RELEASE: go to IDLE. Legal from IDLE as a no-op.
  - 11: state unchanged; ERR <= 1 for one cycle.
- In SHIFT:
  - avail = op_r ? DIN_VALID : 1.
  - DOUT_VALID = avail. DOUT_DATA = CHAIN_OUT.
  - fire = avail & DOUT_RDY.
  - SCAN_MODE = fire. DIN_RDY = op_r & DOUT_RDY.
  - CHAIN_IN = op_r ? DIN_DATA : CHAIN_OUT.
  - DOUT_VALID never depends on DOUT_RDY.
- Outside SHIFT: SCAN_MODE, DOUT_VALID and DIN_RDY are 0. CHAIN_IN = CHAIN_OUT.
- On fire: cnt <= cnt + 1. On fire with cnt == DEPTH-1: cnt <= 0, state <= HELD, DONE <= 1 next cycle.
- Stall (no fire) holds cnt and chain; SCAN_ANY stays 1, so the chain is stable.
- After a READ, the chain holds its original contents in original order. After an EXCHANGE, stage order equals DIN order (first word in ends at tail).

## Timing
- Reset values: state IDLE, cnt 0, DONE 0, ERR 0. Therefore SCAN_ANY 0, SCAN_MODE 0, BUSY 0, CMD_RDY 1, DOUT_VALID 0, DIN_RDY 0.
- Reset assertion is immediate (async) and may occur mid-SHIFT. SCAN_ANY drops at once; the chain resumes sampling D_IN and partial-shift content is discarded. No DONE is issued.
- Command accepted at edge t: SCAN_ANY is high from t. The value captured at edge t is the last D_IN sample. First possible shift is edge t+1.
- Throughput: one stage per cycle with continuous DOUT_RDY (and DIN_VALID). Minimum command-to-DONE = DEPTH+1 cycles.
- DONE is high in the cycle after the final fire, with state already HELD. A new command may be accepted in that same cycle.
- DEPTH == 1: a single fire completes.

## Test plan
- DEPTH=4, SCAN_WIDTH=8, chain loaded 0x11,0x22,0x33,0x44 (tail first); READ with DOUT_RDY=1 -> DOUT 0x11,0x22,0x33,0x44 on 4 consecutive cycles, DONE next cycle, chain unchanged, SCAN_ANY=1 until RELEASE.
- EXCHANGE with DIN 0xA0..0xA3, DOUT_RDY toggled 1,0,1 -> old words out in order; SCAN_MODE only on cycles with DIN_VALID & DOUT_RDY; a follow-up READ returns 0xA0..0xA3.
- DIN_VALID low 3 cycles mid-EXCHANGE -> SCAN_MODE=0, DOUT_VALID=0, cnt frozen; completes after exactly 4 fires.
- Opcode 11 in IDLE and in HELD -> ERR pulses once, state unchanged. RELEASE in IDLE -> accepted, no effect.
- RST_N low after 2 of 4 shifts -> SCAN_ANY, BUSY and SCAN_MODE low immediately, no DONE, CMD_RDY=1 after release.
- DEPTH=1 READ -> one fire, DONE the following cycle.
